xif_mem_responder: RTL and testbench
====================================

Name: xif_mem_responder

Overview:
- Core-side responder for the X-interface memory channel. It accepts coprocessor memory requests (the mem_req / mem_valid / mem_ready handshake), checks them, and forwards them to the data memory over an OBI-style req/gnt/rvalid bus.
- It returns an immediate per-request response (exception flag) and a later, ordered, registered memory result tagged with the request id.
- It sits between the coprocessor's mem port and the data interconnect, and stands in for the core LSU in coprocessor-only integration and in verification.

Parameters:
- ID_WIDTH, 4, width of the X-interface instruction id.
- MAX_OUTSTANDING, 2, maximum granted but not yet responded OBI transactions (power of 2, ≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous flush of the result register
- mem_valid_i  in  1  coprocessor request valid
- mem_ready_o  out  1  request accepted this cycle
- mem_id_i  in  ID_WIDTH  request instruction id
- mem_addr_i  in  32  byte address
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  3  access size in bytes (1, 2, 4 legal)
- mem_be_i  in  4  byte enables
- mem_wdata_i  in  32  store data
- mem_last_i  in  1  last request of instruction (tracked, not acted upon)
- mem_resp_exc_o  out  1  request rejected (misaligned or illegal size); valid when mem_valid_i & mem_ready_o
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  OBI address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  OBI byte enables
- obi_wdata_o  out  32  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI read data
- obi_err_i  in  1  OBI bus error
- mem_result_valid_o  out  1  result valid (one-cycle pulse)
- mem_result_id_o  out  ID_WIDTH  id of completed request
- mem_result_rdata_o  out  32  load data (0 for stores)
- mem_result_err_o  out  1  bus error on this transaction

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. On reset: all registered outputs are 0, the id FIFO is empty and the outstanding count is 0.
- Request check (combinational):
  - bad = size∉{1,2,4} | (size==2 & addr[0]) | (size==4 & addr[1:0]≠0).
  - mem_resp_exc_o = mem_valid_i & bad.
- Bad request: mem_ready_o = 1 in the same cycle, obi_req_o = 0, no FIFO push, no mem_result is ever produced.
- Good request:
  - obi_req_o = mem_valid_i & ~bad & (count < MAX_OUTSTANDING).
  - addr, we, be and wdata pass straight through to the OBI outputs, unregistered.
  - mem_ready_o = obi_req_o & obi_gnt_i.
  - On the handshake, push {id, we} into the id FIFO.
- mem_ready_o is 0 whenever mem_valid_i is 0.
- Push when count == MAX is never performed, even with a same-cycle pop. The request stalls one cycle.
- Push and pop in the same cycle: count is unchanged and FIFO pointers advance independently. Pointers wrap modulo MAX_OUTSTANDING.
- Pop: obi_rvalid_i with the FIFO non-empty pops the head. The next cycle registers:
  - mem_result_valid_o = 1
  - mem_result_id_o = head id
  - mem_result_rdata_o = head.we ? 0 : obi_rdata_i
  - mem_result_err_o = obi_err_i
- Otherwise mem_result_valid_o = 0 and the other result fields hold their last value.
- Latency: grant in cycle T → rvalid ≥ T+1 → result in the rvalid cycle +1. Results come back in grant order.
- obi_rvalid_i with an empty FIFO is a protocol violation: it is ignored, no result is produced, and an assertion fires.
- clear_i: the next cycle has mem_result_valid_o = 0 and result fields = 0. The FIFO and count are unaffected. An rvalid in the clear cycle still pops, but its result is dropped.
- A bad request is accepted even while count == MAX.
- Reset mid-transaction: all tracking is lost. Any rvalid after reset is ignored per the empty-FIFO rule.

Test Plan:
- Aligned word load, addr 0x100, id 3; gnt same cycle; rvalid +2 cycles with rdata 0xDEADBEEF → ready in cycle 0, result {valid, id 3, 0xDEADBEEF, err 0} exactly 1 cycle after rvalid.
- Store word, addr 0x204, wdata 0x12345678, id 5; gnt delayed 3 cycles → obi_req_o held 3 cycles, ready only in the gnt cycle; result id 5 with rdata 0.
- Misaligned word at 0x102, then size 3 at 0x100 → exc=1, ready=1, obi_req_o=0, no mem_result; FIFO stays empty.
- MAX=2: three back-to-back loads (ids 1, 2, 7) with gnt always 1 and rvalid withheld → third stalls (req=0) until first rvalid; results in order 1, 2, 7.
- rvalid with obi_err_i=1 on a load id 4 → result err=1, id 4. rvalid with empty FIFO → no result, assertion flagged.
- clear_i asserted in an rvalid cycle → no result next cycle, count decremented; next request proceeds normally.

Source files
------------

// File: rtl/xif_mem_responder_if.sv
// ----------------------------------------------------------------------------
// xif_mem_responder_if
// Bundles the X-interface memory channel (request, immediate response and
// ordered result) together with the OBI data-memory bus seen by
// xif_mem_responder. Signal suffixes are written from the responder's point
// of view (_i = into the responder, _o = out of it).
//
// Modports:
//   slave  - the responder itself
//   master - the environment (coprocessor mem port + data memory / bench)
//
// Signal groups:
//   mem_*         coprocessor request handshake and immediate exception flag
//   obi_*         OBI req/gnt/rvalid data-memory bus
//   mem_result_*  registered, in-order completion of granted requests
// ----------------------------------------------------------------------------
interface xif_mem_responder_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                mem_valid_i;
    logic                mem_ready_o;
    logic [ID_WIDTH-1:0] mem_id_i;
    logic [31:0]         mem_addr_i;
    logic                mem_we_i;
    logic [2:0]          mem_size_i;
    logic [3:0]          mem_be_i;
    logic [31:0]         mem_wdata_i;
    logic                mem_last_i;
    logic                mem_resp_exc_o;

    logic                obi_req_o;
    logic                obi_gnt_i;
    logic [31:0]         obi_addr_o;
    logic                obi_we_o;
    logic [3:0]          obi_be_o;
    logic [31:0]         obi_wdata_o;
    logic                obi_rvalid_i;
    logic [31:0]         obi_rdata_i;
    logic                obi_err_i;

    logic                mem_result_valid_o;
    logic [ID_WIDTH-1:0] mem_result_id_o;
    logic [31:0]         mem_result_rdata_o;
    logic                mem_result_err_o;

    modport slave (
        input  mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i,
               mem_be_i, mem_wdata_i, mem_last_i,
               obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        output mem_ready_o, mem_resp_exc_o,
               obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
               mem_result_valid_o, mem_result_id_o, mem_result_rdata_o,
               mem_result_err_o
    );

    modport master (
        output mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i,
               mem_be_i, mem_wdata_i, mem_last_i,
               obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  mem_ready_o, mem_resp_exc_o,
               obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
               mem_result_valid_o, mem_result_id_o, mem_result_rdata_o,
               mem_result_err_o
    );
endinterface

// File: rtl/xif_mem_responder.sv
// ----------------------------------------------------------------------------
// xif_mem_responder
// Core-side responder for the X-interface memory channel. Checks each
// coprocessor memory request, rejects misaligned / illegal-size requests with
// an immediate exception, and forwards good requests unregistered onto an
// OBI-style bus. Granted requests are tracked in a small {id, we} FIFO so that
// OBI responses (which return in grant order) can be tagged with the
// originating instruction id and returned as a one-cycle registered result.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clear_i  synchronous flush of the result register (FIFO untouched)
//   bus      xif_mem_responder_if.slave - request, OBI and result signals
//
// Parameters:
//   ID_WIDTH         width of the X-interface instruction id
//   MAX_OUTSTANDING  granted-but-unanswered OBI transactions (power of 2, >=1)
// ----------------------------------------------------------------------------
module xif_mem_responder #(
    parameter int unsigned ID_WIDTH        = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    xif_mem_responder_if.slave   bus
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_WIDTH-1:0] fifo_id_q [MAX_OUTSTANDING];
    logic                fifo_we_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                result_valid_q, result_valid_d;
    logic [ID_WIDTH-1:0] result_id_q, result_id_d;
    logic [31:0]         result_rdata_q, result_rdata_d;
    logic                result_err_q, result_err_d;

    logic size_ok, bad, has_room, fifo_empty, obi_req, push, pop;

    // mem_last_i is carried on the channel but has no effect on this block.
    logic unused_last;
    assign unused_last = bus.mem_last_i;

    // Explicit wrap so the pointer stays modulo MAX_OUTSTANDING even for MAX=1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
        else                                   return p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Request check and OBI forwarding (combinational)
    // ------------------------------------------------------------------------
    assign size_ok = (bus.mem_size_i == 3'd1) | (bus.mem_size_i == 3'd2) |
                     (bus.mem_size_i == 3'd4);
    assign bad     = ~size_ok |
                     ((bus.mem_size_i == 3'd2) & bus.mem_addr_i[0]) |
                     ((bus.mem_size_i == 3'd4) & (|bus.mem_addr_i[1:0]));

    assign has_room   = (count_q < CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    assign obi_req = bus.mem_valid_i & ~bad & has_room;
    assign push    = obi_req & bus.obi_gnt_i;
    // An rvalid with nothing outstanding is dropped here and flagged below.
    assign pop     = bus.obi_rvalid_i & ~fifo_empty;

    assign bus.mem_resp_exc_o = bus.mem_valid_i & bad;
    // Bad requests are consumed immediately, regardless of outstanding count.
    assign bus.mem_ready_o    = (bus.mem_valid_i & bad) | push;

    assign bus.obi_req_o   = obi_req;
    assign bus.obi_addr_o  = bus.mem_addr_i;
    assign bus.obi_we_o    = bus.mem_we_i;
    assign bus.obi_be_o    = bus.mem_be_i;
    assign bus.obi_wdata_o = bus.mem_wdata_i;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        result_valid_d = 1'b0;
        result_id_d    = result_id_q;
        result_rdata_d = result_rdata_q;
        result_err_d   = result_err_q;

        if (clear_i) begin
            // A pop in this cycle still retires its FIFO entry; only the
            // result is discarded.
            result_id_d    = '0;
            result_rdata_d = '0;
            result_err_d   = 1'b0;
        end else if (pop) begin
            result_valid_d = 1'b1;
            result_id_d    = fifo_id_q[rd_ptr_q];
            result_rdata_d = fifo_we_q[rd_ptr_q] ? 32'h0 : bus.obi_rdata_i;
            result_err_d   = bus.obi_err_i;
        end
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            result_rdata_q <= '0;
            result_err_q   <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_id_q[i] <= '0;
                fifo_we_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            result_valid_q <= result_valid_d;
            result_id_q    <= result_id_d;
            result_rdata_q <= result_rdata_d;
            result_err_q   <= result_err_d;
            if (push) begin
                fifo_id_q[wr_ptr_q] <= bus.mem_id_i;
                fifo_we_q[wr_ptr_q] <= bus.mem_we_i;
            end
        end
    end

    assign bus.mem_result_valid_o = result_valid_q;
    assign bus.mem_result_id_o    = result_id_q;
    assign bus.mem_result_rdata_o = result_rdata_q;
    assign bus.mem_result_err_o   = result_err_q;

    // The memory side answered a transaction that was never granted.
    property p_no_orphan_rvalid;
        @(posedge clk_i) disable iff (!rst_ni) bus.obi_rvalid_i |-> !fifo_empty;
    endproperty
    a_no_orphan_rvalid: assert property (p_no_orphan_rvalid)
        else $warning("xif_mem_responder: obi_rvalid_i with no outstanding transaction, ignored");

endmodule

// File: tb/tb_xif_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_xif_mem_responder
// Directed bench for xif_mem_responder. Requests, grants and OBI responses are
// driven cycle by cycle; granted requests are queued as pending, and each
// driven rvalid turns the pending head into an expected result on the
// scoreboard. A negedge monitor pops the scoreboard on every result pulse.
// ----------------------------------------------------------------------------
module tb_xif_mem_responder;

    localparam int ID_W = 4;
    localparam int MAXO = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            we;
    } pend_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     rdata;
        logic            err;
    } res_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        bad;
    } ck_t;

    logic clk_i   = 1'b0;
    logic rst_ni  = 1'b0;
    logic clear_i = 1'b0;

    int checks = 0;
    int errors = 0;

    pend_t pend[$];
    res_t  sb[$];

    xif_mem_responder_if #(.ID_WIDTH(ID_W)) bus ();

    xif_mem_responder #(
        .ID_WIDTH        (ID_W),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive at posedge+1, sample combinational outputs at posedge+4.
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic drive_req(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic we, input logic [2:0] size,
                             input logic [3:0] be, input logic [31:0] wdata,
                             input logic gnt);
        bus.mem_valid_i = 1'b1;
        bus.mem_id_i    = id;
        bus.mem_addr_i  = addr;
        bus.mem_we_i    = we;
        bus.mem_size_i  = size;
        bus.mem_be_i    = be;
        bus.mem_wdata_i = wdata;
        bus.mem_last_i  = 1'b1;
        bus.obi_gnt_i   = gnt;
    endtask

    task automatic idle();
        bus.mem_valid_i = 1'b0;
        bus.mem_id_i    = '0;
        bus.mem_addr_i  = '0;
        bus.mem_we_i    = 1'b0;
        bus.mem_size_i  = 3'd0;
        bus.mem_be_i    = 4'h0;
        bus.mem_wdata_i = '0;
        bus.mem_last_i  = 1'b0;
        bus.obi_gnt_i   = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] rdata, input logic err, input logic clr);
        pend_t p;
        bus.obi_rvalid_i = 1'b1;
        bus.obi_rdata_i  = rdata;
        bus.obi_err_i    = err;
        clear_i          = clr;
        if (pend.size() > 0) begin
            p = pend.pop_front();
            if (!clr) sb.push_back('{id: p.id, rdata: (p.we ? 32'h0 : rdata), err: err});
        end
    endtask

    task automatic rsp_off();
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;
        clear_i          = 1'b0;
    endtask

    task automatic expect_grant(input logic [ID_W-1:0] id, input logic we);
        check("ready_on_grant", 32'(bus.mem_ready_o), 32'd1);
        pend.push_back('{id: id, we: we});
    endtask

    always @(negedge clk_i) begin
        res_t e;
        if (rst_ni && bus.mem_result_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(bus.mem_result_valid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_id",    32'(bus.mem_result_id_o),  32'(e.id));
                check("res_rdata", bus.mem_result_rdata_o,    e.rdata);
                check("res_err",   32'(bus.mem_result_err_o), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        ck_t tbl [6];
        tbl = '{'{32'h102, 3'd4, 1'b1}, '{32'h100, 3'd3, 1'b1},
                '{32'h101, 3'd2, 1'b1}, '{32'h100, 3'd0, 1'b1},
                '{32'h102, 3'd2, 1'b0}, '{32'h103, 3'd1, 1'b0}};

        idle();
        rsp_off();
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        mid();
        check("rst_result_valid", 32'(bus.mem_result_valid_o), 32'd0);
        check("rst_result_id",    32'(bus.mem_result_id_o),    32'd0);
        check("rst_result_rdata", bus.mem_result_rdata_o,      32'd0);
        check("rst_obi_req",      32'(bus.obi_req_o),          32'd0);
        check("rst_ready",        32'(bus.mem_ready_o),        32'd0);

        // Aligned word load, same-cycle grant, rvalid two cycles later.
        nxt(); drive_req(4'd3, 32'h100, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid();
        check("t1_req",  32'(bus.obi_req_o),      32'd1);
        check("t1_exc",  32'(bus.mem_resp_exc_o), 32'd0);
        check("t1_addr", bus.obi_addr_o,          32'h100);
        expect_grant(4'd3, 1'b0);
        nxt(); idle();
        mid(); check("t1_ready_idle", 32'(bus.mem_ready_o), 32'd0);
        nxt(); rsp(32'hDEADBEEF, 1'b0, 1'b0);
        mid(); check("t1_no_early_result", 32'(bus.mem_result_valid_o), 32'd0);
        nxt(); rsp_off();
        mid(); check("t1_result_latency", 32'(bus.mem_result_valid_o), 32'd1);

        // Store with grant withheld for three cycles.
        nxt(); drive_req(4'd5, 32'h204, 1'b1, 3'd4, 4'hA, 32'h12345678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("t2_req_held",   32'(bus.obi_req_o),   32'd1);
            check("t2_no_ready",   32'(bus.mem_ready_o), 32'd0);
            nxt();
        end
        bus.obi_gnt_i = 1'b1;
        mid();
        check("t2_we",    32'(bus.obi_we_o),  32'd1);
        check("t2_wdata", bus.obi_wdata_o,    32'h12345678);
        check("t2_be",    32'(bus.obi_be_o),  32'hA);
        check("t2_addr",  bus.obi_addr_o,     32'h204);
        expect_grant(4'd5, 1'b1);
        nxt(); idle(); rsp(32'hAAAA5555, 1'b0, 1'b0);
        nxt(); rsp_off();

        // Request checker: bad ones are accepted with exc, good ones wait for gnt.
        foreach (tbl[i]) begin
            nxt(); drive_req(4'hE, tbl[i].addr, 1'b0, tbl[i].size, 4'hF, 32'h0, 1'b0);
            mid();
            check("t3_exc",   32'(bus.mem_resp_exc_o), 32'(tbl[i].bad));
            check("t3_ready", 32'(bus.mem_ready_o),    32'(tbl[i].bad));
            check("t3_req",   32'(bus.obi_req_o),      32'(!tbl[i].bad));
        end
        nxt(); idle();

        // Outstanding limit: third load stalls until a response frees a slot.
        nxt(); drive_req(4'd1, 32'h300, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd1, 1'b0);
        nxt(); drive_req(4'd2, 32'h304, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd2, 1'b0);
        nxt(); drive_req(4'd7, 32'h308, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid();
        check("t4_full_req",   32'(bus.obi_req_o),   32'd0);
        check("t4_full_ready", 32'(bus.mem_ready_o), 32'd0);
        nxt(); mid();
        check("t4_still_full", 32'(bus.obi_req_o), 32'd0);
        nxt(); rsp(32'h11111111, 1'b0, 1'b0);
        mid();
        check("t4_no_push_on_pop_req",   32'(bus.obi_req_o),   32'd0);
        check("t4_no_push_on_pop_ready", 32'(bus.mem_ready_o), 32'd0);
        nxt(); rsp(32'h22222222, 1'b0, 1'b0);
        mid(); expect_grant(4'd7, 1'b0);
        nxt(); idle(); rsp(32'h77777777, 1'b0, 1'b0);
        nxt(); rsp_off();

        // Bus error, then an rvalid with nothing outstanding.
        nxt(); drive_req(4'd4, 32'h400, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd4, 1'b0);
        nxt(); idle(); rsp(32'h00000055, 1'b1, 1'b0);
        nxt(); rsp_off();
        nxt(); rsp(32'h00000099, 1'b0, 1'b0);
        nxt(); rsp_off();
        mid(); check("t5_orphan_no_result", 32'(bus.mem_result_valid_o), 32'd0);

        // clear_i in an rvalid cycle drops that result but frees the slot.
        nxt(); drive_req(4'd9, 32'h500, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd9, 1'b0);
        nxt(); drive_req(4'd11, 32'h504, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd11, 1'b0);
        nxt(); idle(); rsp(32'h90909090, 1'b0, 1'b1);
        nxt(); rsp_off(); drive_req(4'd12, 32'h508, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid();
        check("t6_clr_valid", 32'(bus.mem_result_valid_o), 32'd0);
        check("t6_clr_id",    32'(bus.mem_result_id_o),    32'd0);
        check("t6_clr_rdata", bus.mem_result_rdata_o,      32'd0);
        check("t6_clr_err",   32'(bus.mem_result_err_o),   32'd0);
        expect_grant(4'd12, 1'b0);
        nxt(); idle(); rsp(32'hBBBB0011, 1'b0, 1'b0);
        nxt(); rsp(32'hCCCC0012, 1'b0, 1'b0);
        nxt(); rsp_off();

        // Reset with a transaction outstanding: its late rvalid is ignored.
        nxt(); drive_req(4'd6, 32'h600, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd6, 1'b0);
        nxt(); idle(); rst_ni = 1'b0;
        mid();
        check("t7_rst_rdata", bus.mem_result_rdata_o, 32'd0);
        nxt(); rst_ni = 1'b1; pend.delete();
        nxt(); rsp(32'h66666666, 1'b0, 1'b0);
        nxt(); rsp_off();
        mid(); check("t7_no_result_after_rst", 32'(bus.mem_result_valid_o), 32'd0);
        nxt(); drive_req(4'd15, 32'h700, 1'b0, 3'd4, 4'hF, 32'h0, 1'b1);
        mid(); expect_grant(4'd15, 1'b0);
        nxt(); idle(); rsp(32'h0F0F0F0F, 1'b0, 1'b0);
        nxt(); rsp_off();

        nxt(); nxt();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
